// File: rtl/cache_pkg.sv
// Shared definitions for the cache controller: FSM state encoding and the
// default line geometry (32-bit words, 32 sets, 64-byte lines).
package cache_pkg;

    localparam int WORD_SIZE      = 32;
    localparam int INDEX_BITS     = 5;
    localparam int BLOCK_OFFSET   = 6;
    localparam int WORDS_PER_LINE = (2**BLOCK_OFFSET * 8) / WORD_SIZE;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        FILL   = 2'd2,
        WRITE  = 2'd3
    } state_t;

endpackage

// File: rtl/line_assembler.sv
// Collects a cache line one word at a time during a refill. The word
// counter doubles as the refill address offset for the controller.
module line_assembler
    import cache_pkg::*;
#(
    parameter int unsigned W  = WORD_SIZE,
    parameter int unsigned N  = WORDS_PER_LINE,
    localparam int unsigned CW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic           capture,
    input  logic [W-1:0]   wdata,
    output logic [CW-1:0]  cnt,
    output logic [N*W-1:0] line,
    output logic           last
);

    logic [N-1:0][W-1:0] words;

    // Capture register and word counter; clear only rewinds the counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            words <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (capture) begin
            words[cnt] <= wdata;
            cnt        <= cnt + 1'b1;
        end
    end

    assign line = words;
    assign last = (cnt == CW'(N - 1));

endmodule

// File: rtl/cache_ctrl.sv
// Write-through, no-write-allocate cache controller with zero-latency read
// hits and a word-serial line refill.
// Optional feature: define CACHE_CTRL_STATS_EN to add hit/miss counters.
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int WORD_SIZE    = cache_pkg::WORD_SIZE,
    parameter int INDEX_BITS   = cache_pkg::INDEX_BITS,
    parameter int BLOCK_OFFSET = cache_pkg::BLOCK_OFFSET,
    parameter int TAG_BITS     = 32 - INDEX_BITS - BLOCK_OFFSET,
    parameter int LINE_LENGTH  = TAG_BITS + 2**BLOCK_OFFSET * 8 + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            cpu_addr,
    input  logic                   cpu_re,
    input  logic                   cpu_wr,
    input  logic [WORD_SIZE-1:0]   cpu_wdata,
    output logic [WORD_SIZE-1:0]   cpu_rdata,
    output logic                   cpu_stall,
    output logic [31:0]            cache_addr,
    output logic                   cache_re,
    output logic                   cache_wr,
    output logic                   cache_enable,
    output logic                   cache_full_line_wr,
    output logic [LINE_LENGTH-1:0] cache_new_line,
    input  logic                   cache_hit,
    input  logic [WORD_SIZE-1:0]   cache_data_out,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [31:0]            mem_addr,
    output logic [WORD_SIZE-1:0]   mem_wdata,
    input  logic [WORD_SIZE-1:0]   mem_rdata,
    input  logic                   mem_ack
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [31:0]            hit_count,
    output logic [31:0]            miss_count
`endif
);

    localparam int WORDS = (2**BLOCK_OFFSET * 8) / WORD_SIZE;
    localparam int CNT_W = $clog2(WORDS);

    state_t                   state, state_nx;
    logic                     la_clear, la_capture, la_last;
    logic [CNT_W-1:0]         la_cnt;
    logic [WORDS*WORD_SIZE-1:0] la_line;
    logic                     rd_hit, wr_done;

    line_assembler #(
        .W (WORD_SIZE),
        .N (WORDS)
    ) u_line (
        .clk     (clk),
        .rst     (rst),
        .clear   (la_clear),
        .capture (la_capture),
        .wdata   (mem_rdata),
        .cnt     (la_cnt),
        .line    (la_line),
        .last    (la_last)
    );

    // State register; reset abandons any refill or write in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next state and all outputs; every output is held low while in reset.
    always_comb begin
        state_nx           = state;
        la_clear           = 1'b0;
        la_capture         = 1'b0;
        rd_hit             = 1'b0;
        wr_done            = 1'b0;
        cpu_rdata          = '0;
        cpu_stall          = 1'b0;
        cache_addr         = '0;
        cache_re           = 1'b0;
        cache_wr           = 1'b0;
        cache_enable       = 1'b0;
        cache_full_line_wr = 1'b0;
        cache_new_line     = '0;
        mem_req            = 1'b0;
        mem_we             = 1'b0;
        mem_addr           = '0;
        mem_wdata          = '0;
        if (rst) begin
            cache_enable   = 1'b1;
            cache_addr     = cpu_addr;
            cpu_rdata      = cache_data_out;
            cache_new_line = {cpu_addr[31 -: TAG_BITS], la_line, 1'b1};
            case (state)
                IDLE: begin
                    cache_re = cpu_re;
                    if (cpu_re) begin
                        if (cache_hit) begin
                            rd_hit = 1'b1;
                        end else begin
                            la_clear = 1'b1;
                            state_nx = REFILL;
                        end
                    end else if (cpu_wr) begin
                        state_nx = WRITE;
                    end
                end
                REFILL: begin
                    mem_req  = 1'b1;
                    mem_addr = {cpu_addr[31:BLOCK_OFFSET], {BLOCK_OFFSET{1'b0}}}
                               | (32'(la_cnt) << 2);
                    if (mem_ack) begin
                        la_capture = 1'b1;
                        if (la_last) state_nx = FILL;
                    end
                end
                FILL: begin
                    cache_full_line_wr = 1'b1;
                    state_nx           = IDLE;
                end
                WRITE: begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = cpu_addr;
                    mem_wdata = cpu_wdata;
                    if (mem_ack) begin
                        cache_wr = 1'b1;
                        wr_done  = 1'b1;
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
            cpu_stall = (cpu_re | cpu_wr) & ~rd_hit & ~wr_done;
        end
    end

`ifdef CACHE_CTRL_STATS_EN
    // Hit counter counts completed read hits; miss counter counts refill starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (rd_hit)   hit_count  <= hit_count + 32'd1;
            if (la_clear) miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule
